// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one fetch at a time at the current PC,
// presents {inst, pc} to the decode stage and waits for the next PC from
// write-back before fetching again.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC       = 32'h8000_0000,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst,              // asynchronous, active-low
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        ifu_valid,
   output logic [63:0] ifu_data,
   input  logic        idu_ready,
   input  logic        wbu_valid,
   input  logic [31:0] wbu_npc,
   output logic        fetch_err
);

   localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT_RESP,
      S_HOLD,
      S_WAIT_NPC,
      S_ERR
   } state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [63:0]     data_q, data_d;
   logic [31:0]     npc_q, npc_d;
   logic            pend_q, pend_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            err_q, err_d;

   // State register; reset abandons any outstanding request or response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         data_q  <= '0;
         npc_q   <= '0;
         pend_q  <= 1'b0;
         timer_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         data_q  <= data_d;
         npc_q   <= npc_d;
         pend_q  <= pend_d;
         timer_q <= timer_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic: fetch sequencing, timeout and early next-PC capture.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      data_d  = data_q;
      npc_d   = npc_q;
      pend_d  = pend_q;
      timer_d = timer_q;
      err_d   = err_q;

      // A next PC arriving before we are waiting for it is parked; a second
      // one before consumption simply overwrites the first.
      if (wbu_valid && (state_q != S_WAIT_NPC) && (state_q != S_ERR)) begin
         npc_d  = wbu_npc;
         pend_d = 1'b1;
      end

      case (state_q)
         S_BOOT: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            if (imem_req_ready) begin
               state_d = S_WAIT_RESP;
               timer_d = '0;
            end
         end
         S_WAIT_RESP: begin
            // A response on the last allowed cycle beats the timeout.
            if (imem_resp_valid) begin
               data_d  = {imem_resp_data, pc_q};
               state_d = S_HOLD;
            end else if (timer_q == TIMER_LAST) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_HOLD: begin
            if (idu_ready) begin
               if (wbu_valid) begin
                  pc_d    = wbu_npc;
                  pend_d  = 1'b0;
                  state_d = S_REQ;
               end else if (pend_q) begin
                  pc_d    = npc_q;
                  pend_d  = 1'b0;
                  state_d = S_REQ;
               end else begin
                  state_d = S_WAIT_NPC;
               end
            end
         end
         S_WAIT_NPC: begin
            if (wbu_valid) begin
               pc_d    = wbu_npc;
               state_d = S_REQ;
            end
         end
         S_ERR: begin
            state_d = S_ERR;
         end
         default: begin
            state_d = S_ERR;
         end
      endcase
   end

   // Outputs are pure decodes of registered state.
   assign imem_req_valid = (state_q == S_REQ);
   assign imem_req_addr  = pc_q;
   assign ifu_valid      = (state_q == S_HOLD);
   assign ifu_data       = data_q;
   assign fetch_err      = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed self-checking bench for ifu_fetch with address and data scoreboards.
module tb_ifu_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        ifu_valid;
   logic [63:0] ifu_data;
   logic        idu_ready;
   logic        wbu_valid;
   logic [31:0] wbu_npc;
   logic        fetch_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int req_cnt      = 0;

   logic [31:0] exp_addr_q[$];
   logic [63:0] exp_data_q[$];
   logic [31:0] last_addr;

   ifu_fetch #(
      .RESET_PC       (32'h8000_0000),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .ifu_valid       (ifu_valid),
      .ifu_data        (ifu_data),
      .idu_ready       (idu_ready),
      .wbu_valid       (wbu_valid),
      .wbu_npc         (wbu_npc),
      .fetch_err       (fetch_err)
   );

   always #5 clk = ~clk;

   // Counts request handshakes seen by the memory.
   always @(posedge clk) begin
      if (rst && imem_req_valid && imem_req_ready) req_cnt <= req_cnt + 1;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Check the pending request against the scoreboard, then accept it.
   task automatic do_req(input string tag);
      logic [31:0] e;
      e = (exp_addr_q.size() != 0) ? exp_addr_q[0] : 32'hxxxx_xxxx;
      chk({tag, "_valid"}, {63'd0, imem_req_valid}, 64'd1);
      chk({tag, "_addr"}, {32'd0, imem_req_addr}, {32'd0, e});
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
      last_addr = e;
      $display("[TB] %s: request accepted addr=%h", tag, e);
   endtask

   // Return an instruction word for the outstanding fetch.
   task automatic do_resp(input logic [31:0] inst);
      imem_resp_valid = 1'b1;
      imem_resp_data  = inst;
      exp_data_q.push_back({inst, last_addr});
      tick();
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      $display("[TB] response inst=%h for pc=%h", inst, last_addr);
   endtask

   // Check the presented {inst,pc} against the scoreboard, then accept it.
   task automatic do_accept(input string tag);
      logic [63:0] e;
      e = (exp_data_q.size() != 0) ? exp_data_q[0] : 64'hx;
      chk({tag, "_ifu_valid"}, {63'd0, ifu_valid}, 64'd1);
      chk({tag, "_ifu_data"}, ifu_data, e);
      idu_ready = 1'b1;
      tick();
      idu_ready = 1'b0;
      if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
      $display("[TB] %s: IDU accepted data=%h", tag, e);
   endtask

   initial begin
      int req_cnt0;
      rst             = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      idu_ready       = 1'b0;
      wbu_valid       = 1'b0;
      wbu_npc         = 32'h0;
      last_addr       = 32'h0;

      // Reset state
      repeat (2) tick();
      chk("rst_req_valid", {63'd0, imem_req_valid}, 64'd0);
      chk("rst_ifu_valid", {63'd0, ifu_valid}, 64'd0);
      chk("rst_ifu_data", ifu_data, 64'd0);
      chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
      rst = 1'b1;
      exp_addr_q.push_back(32'h8000_0000);
      tick();

      // 1: first fetch at reset PC, response two cycles after acceptance
      do_req("t1");
      chk("t1_req_dropped", {63'd0, imem_req_valid}, 64'd0);
      tick();
      do_resp(32'h0000_0013);
      chk("t1_ifu_valid", {63'd0, ifu_valid}, 64'd1);
      chk("t1_ifu_data", ifu_data, 64'h0000_0013_8000_0000);

      // 2: IDU stalls 5 cycles, accepts on the 6th
      for (int i = 0; i < 5; i++) begin
         chk("t2_hold_valid", {63'd0, ifu_valid}, 64'd1);
         chk("t2_hold_data", ifu_data, exp_data_q.size() != 0 ? exp_data_q[0] : 64'hx);
         tick();
      end
      do_accept("t2");
      for (int i = 0; i < 3; i++) begin
         chk("t2_npc_ifu_valid", {63'd0, ifu_valid}, 64'd0);
         chk("t2_npc_no_req", {63'd0, imem_req_valid}, 64'd0);
         tick();
      end

      // 3: memory back-pressures the request for 3 cycles
      wbu_valid = 1'b1;
      wbu_npc   = 32'h8000_0004;
      exp_addr_q.push_back(32'h8000_0004);
      tick();
      wbu_valid = 1'b0;
      req_cnt0  = req_cnt;
      for (int i = 0; i < 3; i++) begin
         chk("t3_stall_valid", {63'd0, imem_req_valid}, 64'd1);
         chk("t3_stall_addr", {32'd0, imem_req_addr}, 64'h8000_0004);
         tick();
      end
      do_req("t3");
      chk("t3_single_req", req_cnt, req_cnt0 + 1);

      // 4: early next PC during the response wait skips S_WAIT_NPC
      wbu_valid = 1'b1;
      wbu_npc   = 32'h8000_0010;
      exp_addr_q.push_back(32'h8000_0010);
      tick();
      wbu_valid = 1'b0;
      do_resp(32'h0010_0093);
      do_accept("t4");
      do_req("t4_early");

      // Accept and next PC in the same cycle go straight to the new PC
      do_resp(32'h0020_0113);
      chk("sim_ifu_data", ifu_data, 64'h0020_0113_8000_0010);
      idu_ready = 1'b1;
      wbu_valid = 1'b1;
      wbu_npc   = 32'h8000_0020;
      exp_addr_q.push_back(32'h8000_0020);
      tick();
      idu_ready = 1'b0;
      wbu_valid = 1'b0;
      if (exp_data_q.size() != 0) void'(exp_data_q.pop_front());
      do_req("sim");

      // Response on the last allowed wait cycle wins over the timeout
      repeat (7) tick();
      do_resp(32'h0030_0193);
      chk("edge_no_err", {63'd0, fetch_err}, 64'd0);
      do_accept("edge");
      wbu_valid = 1'b1;
      wbu_npc   = 32'h8000_0030;
      exp_addr_q.push_back(32'h8000_0030);
      tick();
      wbu_valid = 1'b0;
      do_req("t5");

      // 5: no response -> timeout after 8 wait cycles, terminal
      repeat (6) tick();
      chk("t5_err_early", {63'd0, fetch_err}, 64'd0);
      chk("t5_wait_ifu_valid", {63'd0, ifu_valid}, 64'd0);
      repeat (2) tick();
      chk("t5_err_set", {63'd0, fetch_err}, 64'd1);
      imem_req_ready  = 1'b1;
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hdead_beef;
      idu_ready       = 1'b1;
      wbu_valid       = 1'b1;
      wbu_npc         = 32'h8000_0040;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("t5_err_req_valid", {63'd0, imem_req_valid}, 64'd0);
         chk("t5_err_ifu_valid", {63'd0, ifu_valid}, 64'd0);
         chk("t5_err_sticky", {63'd0, fetch_err}, 64'd1);
      end
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      idu_ready       = 1'b0;
      wbu_valid       = 1'b0;

      // Reset clears the error asynchronously
      rst = 1'b0;
      #1;
      chk("t5_rst_err", {63'd0, fetch_err}, 64'd0);
      tick();
      rst = 1'b1;
      exp_addr_q.push_back(32'h8000_0000);
      tick();
      do_req("t6_pre");
      do_resp(32'h0040_0213);
      chk("t6_hold_valid", {63'd0, ifu_valid}, 64'd1);

      // 6: reset in S_HOLD drops ifu_valid at once; refetch from reset PC
      rst = 1'b0;
      #1;
      chk("t6_async_valid", {63'd0, ifu_valid}, 64'd0);
      chk("t6_async_data", ifu_data, 64'd0);
      exp_data_q.delete();
      exp_addr_q.push_back(32'h8000_0000);
      tick();
      rst = 1'b1;
      tick();
      do_req("t6");

      chk("end_addr_q_empty", exp_addr_q.size(), 64'd0);
      chk("end_data_q_empty", exp_data_q.size(), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
